// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle logic ops, W-cycle shift-add multiply.
// Optional zero/high-half flags are compiled in with `define ALU_MC_FLAGS_EN.
module alu_mc #(
  parameter int W = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] o
`ifdef ALU_MC_FLAGS_EN
  ,
  output logic           zf,
  output logic           hf
`endif
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e           state_q;
  logic [2*W-1:0]   o_q;
  logic [2*W-1:0]   mcand_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     mplier_q;
  logic [CW-1:0]    cnt_q;

  logic [2*W-1:0]   alu_d;
  logic [2*W-1:0]   acc_d;
  logic [2*W-1:0]   o_d;
  logic             o_load;

  // Single-cycle result; bit W of the (W+1)-bit difference is the borrow.
  always_comb begin
    alu_d = '0;
    case (s)
      3'b000:  alu_d[W:0]   = {1'b0, a} + {1'b0, b};
      3'b010:  alu_d[W:0]   = {1'b0, a} - {1'b0, b};
      3'b011:  alu_d[0]     = (a != b);
      3'b100:  alu_d[W-1:0] = a & b;
      3'b101:  alu_d[W-1:0] = a | b;
      3'b110:  alu_d[W-1:0] = a ^ b;
      3'b111:  alu_d[W-1:0] = ~a;
      default: alu_d        = '0;
    endcase
  end

  always_comb begin
    acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    o_load = 1'b0;
    o_d    = alu_d;
    if (state_q == IDLE) begin
      o_load = in_valid && (s != 3'b001);
    end else if (state_q == MUL) begin
      o_load = (cnt_q == CW'(1));
      o_d    = acc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      o_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_MC_FLAGS_EN
      zf       <= 1'b1;
      hf       <= 1'b0;
`endif
    end else begin
      if (o_load) begin
        o_q <= o_d;
`ifdef ALU_MC_FLAGS_EN
        zf  <= (o_d == '0);
        hf  <= (o_d[2*W-1:W] != '0);
`endif
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (s == 3'b001) begin
              mcand_q  <= {{W{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= CW'(W);
              state_q  <= MUL;
            end else begin
              state_q  <= DONE;
            end
          end
        end
        MUL: begin
          // Fixed W iterations regardless of operand values.
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign o         = o_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc (W=4) against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     s = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*W-1:0] o;
`ifdef ALU_MC_FLAGS_EN
  logic           zf;
  logic           hf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.W(W)) dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o)
`ifdef ALU_MC_FLAGS_EN
    ,
    .zf        (zf),
    .hf        (hf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_result(input int unsigned av, input int unsigned bv,
                                             input int unsigned op);
    case (op)
      0: return av + bv;
      1: return av * bv;
      2: return ((av - bv) & MASK) | ((av < bv) ? (1 << W) : 0);
      3: return (av != bv) ? 1 : 0;
      4: return av & bv;
      5: return av | bv;
      6: return av ^ bv;
      default: return (~av) & MASK;
    endcase
  endfunction

  task automatic check_flags(input string tag, input int unsigned exp);
`ifdef ALU_MC_FLAGS_EN
    check({tag, ".zf"}, 64'(zf), 64'(exp == 0));
    check({tag, ".hf"}, 64'(hf), 64'((exp >> W) != 0));
`else
    if (exp > 32'hFFFF) $display("note %s: unexpected wide result", tag);
`endif
  endtask

  // Issue one op, wait for the result, optionally stall, then consume it.
  task automatic run_op(input int unsigned av, input int unsigned bv, input int unsigned op,
                        input int stall, input string tag);
    int unsigned exp;
    int          lat;
    int          exp_lat;
    exp     = ref_result(av, bv, op);
    exp_lat = (op == 1) ? W + 1 : 1;
    @(negedge clk);
    check({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
    a = W'(av); b = W'(bv); s = 3'(op); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); s = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); s = 3'($urandom);
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".o"}, 64'(o), 64'(exp));
    check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    check_flags(tag, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); s = 3'($urandom);
      @(posedge clk); #1;
      check({tag, ".stall_o"}, 64'(o), 64'(exp));
      check({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".post_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, ".post_hold"}, 64'(o), 64'(exp));
    $display("txn %s: s=%0d a=0x%0h b=0x%0h o=0x%0h exp=0x%0h lat=%0d stall=%0d",
             tag, op, av, bv, o, exp, lat, stall);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.o", 64'(o), 64'd0);
    check_flags("reset", 0);
    reset_n = 1'b1;

    run_op(9, 8, 0, 0, "add");
    run_op(15, 15, 1, 0, "mul_ff");
    run_op(7, 0, 1, 0, "mul_b0");
    run_op(3, 5, 2, 0, "sub_borrow");
    run_op(5, 3, 2, 0, "sub");
    run_op(10, 10, 3, 0, "neq_eq");
    run_op(12, 10, 4, 0, "and");
    run_op(12, 10, 5, 0, "or");
    run_op(12, 10, 6, 0, "xor");
    run_op(5, 0, 7, 0, "not");
    run_op(6, 7, 0, 10, "backpressure");

    // Output and input handshakes together in DONE: only the output completes.
    @(negedge clk);
    a = W'(1); b = W'(2); s = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = W'(6); b = W'(1); s = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("overlap.out_valid", 64'(out_valid), 64'd0);
    check("overlap.in_ready", 64'(in_ready), 64'd1);
    check("overlap.o_old", 64'(o), 64'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("overlap.second_valid", 64'(out_valid), 64'd1);
    check("overlap.second_o", 64'(o), 64'd7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn overlap: first o=0x3 second o=0x%0h", o);

    // Reset during the second MUL cycle discards the product.
    run_op(9, 8, 0, 0, "pre_reset");
    @(negedge clk);
    a = W'(15); b = W'(15); s = 3'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midreset.in_ready", 64'(in_ready), 64'd1);
    check("midreset.out_valid", 64'(out_valid), 64'd0);
    check("midreset.o", 64'(o), 64'd0);
    check_flags("midreset", 0);
    $display("txn midreset: o=0x%0h in_ready=%0d out_valid=%0d", o, in_ready, out_valid);
    run_op(9, 8, 0, 0, "post_reset_add");

    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 7),
             $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the team's registered 4-bit ALU. It takes operands `a`/`b` and a 3-bit opcode through a valid/ready input port and returns a 2·W-bit result through a valid/ready output port. Multiplication runs as a W-cycle shift-add sequence; every other operation completes in one cycle. The block sits between the operand register file and the result writeback stage. It holds its result until the consumer takes it.

## Interface
- `W`, default 4: operand width in bits; legal range 2..32. Result width is 2·W.
- `clock` input, 1 bit: single clock; all state updates on rising edge.
- `reset_n` input, 1 bit: synchronous, active-low reset, sampled on rising edge of `clock`.
- `in_valid` input, 1 bit: operand/opcode present.
- `in_ready` output, 1 bit: block can accept an operation.
- `a` input, W bits: operand A, unsigned.
- `b` input, W bits: operand B, unsigned.
- `s` input, 3 bits: opcode.
- `out_valid` output, 1 bit: `o` holds a completed result.
- `out_ready` input, 1 bit: consumer accepts the result.
- `o` output, 2·W bits: result.
- `zf` output, 1 bit: zero flag. Present only with `ALU_MC_FLAGS_EN`.
- `hf` output, 1 bit: high-half-nonzero flag. Present only with `ALU_MC_FLAGS_EN`.

## Operation
- **States:**
  - IDLE: `in_ready`=1.
  - MUL: multiplying.
  - DONE: `out_valid`=1.
- **Accept:** an operation is accepted when `in_valid` && `in_ready` at a rising edge.
- **Opcodes:** all unsigned; every result is zero-extended to 2·W.
  - 000 add: `o` = a+b; the carry lands in bit W.
  - 001 mul: `o` = a·b, full 2·W-bit product.
  - 010 sub: `o`[W-1:0] = (a−b) mod 2^W; `o`[W] = borrow (a<b); higher bits 0.
  - 011 neq: `o` = 1 if a≠b, else 0.
  - 100 and, 101 or, 110 xor: bitwise on W bits.
  - 111 not: `o` = ~a on W bits.
- **IDLE, accepted non-mul op:** register the result into `o` and go to DONE.
- **IDLE, accepted mul:**
  - Load multiplicand (2·W, zero-extended a) and multiplier (b).
  - Clear the accumulator and set the counter to W.
  - Go to MUL.
- **MUL, each cycle:**
  - If multiplier[0]=1, accumulator += multiplicand.
  - Shift the multiplicand left 1 and the multiplier right 1, and decrement the counter.
  - When the counter reaches 0 after the update, copy the accumulator to `o` and go to DONE.
- **No early exit:** MUL always takes exactly W cycles, even when b=0.
- **DONE:**
  - `o` and the flags are stable.
  - On `out_ready`=1, go to IDLE.
  - `o` holds its value after leaving DONE, but is not valid.
- **Input while busy:** `in_valid` is ignored in MUL and DONE. Operands need to be stable only in the accept cycle.
- **Reset:** `reset_n`=0 at an edge forces IDLE from any state, including mid-MUL or DONE with `out_valid` high. The pending result is discarded.

## Timing
- **Reset values:**
  - `in_ready`=1, `out_valid`=0, `o`=0.
  - `zf`=1, `hf`=0 (flags only with the macro).
  - Internal accumulator and counter = 0.
- **`in_ready` / `out_valid`:** both are registered state decodes. `in_ready`=(state==IDLE) and `out_valid`=(state==DONE); no combinational path from the inputs.
- **Latency, accept edge → `out_valid` high:**
  - Non-mul: 1 cycle.
  - Mul: W+1 cycles.
- **Throughput:**
  - Non-mul: one operation per 2 cycles, with `out_ready` held high.
  - Mul: one per W+2 cycles.
- **Backpressure:** with `out_ready`=0, DONE holds indefinitely and `in_ready` stays 0.
- **Handshake overlap:** `out_ready` and `in_valid` may both be high in DONE. Only the output handshake completes; the input is accepted in the following IDLE cycle.

## Configuration
- **`ALU_MC_FLAGS_EN` defined:**
  - `zf` and `hf` ports exist and are registered in the same edge as `o`.
  - `zf` = (result==0).
  - `hf` = (result[2W-1:W] ≠ 0).
- **`ALU_MC_FLAGS_EN` undefined:**
  - Ports and flag logic are absent.
  - All other behaviour is identical.

## Test plan
All cases use W=4.
- **Add:** a=9, b=8, s=000 → 1 cycle later `out_valid`=1, `o`=0x11; with flags, `zf`=0, `hf`=1.
- **Mul:** a=15, b=15, s=001 → `out_valid` rises exactly 5 cycles after accept, `o`=0xE1. Then a=7, b=0 → `o`=0x00, `zf`=1, still 5 cycles.
- **Sub:** a=3, b=5, s=010 → `o`=0x1E. Then a=5, b=3 → `o`=0x02.
- **Remaining ops:**
  - a=0xA, b=0xA, s=011 → `o`=0.
  - a=0xC, b=0xA: and → 0x08; or → 0x0E; xor → 0x06.
  - s=111, a=0x5 → 0x0A.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after a result → `o` stable, `out_valid`=1, `in_ready`=0, and new `in_valid` ignored. Raise `out_ready` → IDLE next cycle.
- **Reset mid-operation:** `reset_n`=0 on the 2nd cycle of MUL → next cycle `in_ready`=1, `out_valid`=0, `o`=0. A subsequent add completes normally.
